// File: rtl/row_ser_pkg.sv
// Shared constants and state type for the row serializer slice.
package row_ser_pkg;

    localparam int                BITS_ADC  = 12;
    localparam int                WORD_W    = BITS_ADC + 1;
    localparam logic [7:0]        SYNC_WORD = 8'hA5;
    localparam logic [WORD_W-1:0] IDLE_WORD = '1;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        WAIT,
        DATA,
        DONE
    } state_e;

endpackage

// File: rtl/sync_word_fifo.sv
// Synchronous word FIFO with occupancy output; full/empty are derived from the level.
module sync_word_fifo
    import row_ser_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = WORD_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FULL_LEVEL);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A full FIFO refuses the push even when a pop happens in the same cycle; a pop against an empty FIFO is ignored.
    always_comb begin
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_push && do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // Pointer and level registers; a flush empties the FIFO exactly like reset.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/row_serializer.sv
// Captures daisy-chain words for one row and emits frames (sync byte + words) MSB-first.
module row_serializer
    import row_ser_pkg::*;
#(
    parameter int WORDS_PER_FRAME = 32,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                        clk_50M,
    input  logic                        rst,
    input  logic [WORD_W-1:0]           word_in,
    input  logic                        word_stb,
    input  logic                        frame_start,
    output logic                        s_data,
    output logic                        data_valid,
    output logic                        frame_done,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int                 CNT_W     = $clog2((WORD_W > 8) ? WORD_W : 8);
    localparam int                 WC_W      = $clog2(WORDS_PER_FRAME) + 1;
    localparam logic [CNT_W-1:0]   SYNC_TOP  = CNT_W'(7);
    localparam logic [CNT_W-1:0]   WORD_TOP  = CNT_W'(BITS_ADC);
    localparam logic [WC_W-1:0]    LAST_WORD = WC_W'(WORDS_PER_FRAME - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic               overflow_q, overflow_d;

    logic               abort;
    logic               push_req;
    logic               pop_req;
    logic               fifo_full;
    logic               fifo_empty;
    logic [WORD_W-1:0]  fifo_data;
    logic               s_data_c;
    logic               valid_c;
    logic               done_c;

    assign abort    = frame_start & (state_q != IDLE);
    assign push_req = word_stb & (word_in != IDLE_WORD) & (state_q != IDLE) & ~frame_start;

    sync_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk_i   (clk_50M),
        .rst_i   (rst),
        .flush_i (abort),
        .push_i  (push_req),
        .pop_i   (pop_req),
        .data_i  (word_in),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Frame sequencing and shifting; at the end of the header or of a word the next
    // buffered word is loaded straight away so data_valid only drops while starved.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        shreg_d    = shreg_q;
        pop_req    = 1'b0;
        s_data_c   = 1'b0;
        valid_c    = 1'b0;
        done_c     = 1'b0;
        overflow_d = overflow_q | (push_req & fifo_full);

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d    = SYNC;
                    bit_cnt_d  = SYNC_TOP;
                    word_cnt_d = '0;
                end
            end
            SYNC: begin
                s_data_c = SYNC_WORD[bit_cnt_q[2:0]];
                valid_c  = 1'b1;
                if (bit_cnt_q == '0) begin
                    if (!fifo_empty) begin
                        pop_req   = 1'b1;
                        shreg_d   = fifo_data;
                        bit_cnt_d = WORD_TOP;
                        state_d   = DATA;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            WAIT: begin
                if (!fifo_empty) begin
                    pop_req   = 1'b1;
                    shreg_d   = fifo_data;
                    bit_cnt_d = WORD_TOP;
                    state_d   = DATA;
                end
            end
            DATA: begin
                s_data_c = shreg_q[WORD_W-1];
                valid_c  = 1'b1;
                if (bit_cnt_q == '0) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = DONE;
                    end else if (!fifo_empty) begin
                        pop_req   = 1'b1;
                        shreg_d   = fifo_data;
                        bit_cnt_d = WORD_TOP;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d    = SYNC;
            bit_cnt_d  = SYNC_TOP;
            word_cnt_d = '0;
            pop_req    = 1'b0;
        end
    end

    // State, counters, shift register and sticky overflow flag.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            shreg_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            shreg_q    <= shreg_d;
            overflow_q <= overflow_d;
        end
    end

    assign s_data     = s_data_c;
    assign data_valid = valid_c;
    assign frame_done = done_c;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_row_serializer.sv
// Self-checking bench for row_serializer against a timeline model of frames.
module tb_row_serializer;
    import row_ser_pkg::*;

    localparam int WPF   = 4;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk         = 1'b0;
    logic              rst         = 1'b0;
    logic              word_stb    = 1'b0;
    logic              frame_start = 1'b0;
    logic [WORD_W-1:0] word_in     = '0;
    logic              s_data;
    logic              data_valid;
    logic              frame_done;
    logic              overflow;
    logic [LW-1:0]     fifo_level;

    row_serializer #(
        .WORDS_PER_FRAME (WPF),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk_50M     (clk),
        .rst         (rst),
        .word_in     (word_in),
        .word_stb    (word_stb),
        .frame_start (frame_start),
        .s_data      (s_data),
        .data_valid  (data_valid),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
    );

    // 50 MHz-style free-running clock.
    always #10 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    int capBit[$];
    int capCyc[$];
    int doneCnt;
    int doneCyc;
    int maxLevel;
    int firstLevel;
    int lastLevel;
    int cyc;
    bit ovfExp = 1'b0;

    int                schedCyc[$];
    logic [WORD_W-1:0] schedWord[$];

    task automatic checkOutput(input string tag, input int actual, input int expected);
        testCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
        end
    endtask

    // Samples outputs of the current cycle, then drives the inputs of that same cycle.
    task automatic applyStimulus(input logic fs, input logic stb, input logic [WORD_W-1:0] w);
        @(negedge clk);
        if (cyc >= 1) begin
            if (data_valid) begin
                capBit.push_back(int'(s_data));
                capCyc.push_back(cyc);
            end
            if (frame_done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            if (int'(fifo_level) > maxLevel) maxLevel = int'(fifo_level);
            if (cyc == 1) firstLevel = int'(fifo_level);
            lastLevel = int'(fifo_level);
        end
        frame_start = fs;
        word_stb    = stb;
        word_in     = w;
        cyc++;
    endtask

    task automatic addWord(input int c, input logic [WORD_W-1:0] w);
        schedCyc.push_back(c);
        schedWord.push_back(w);
    endtask

    // Cycle 0 carries frame_start; the schedule holds strobes relative to it.
    task automatic runFrame(input string tag, input int nCycles, input bit doCheck);
        int                accCyc[$];
        logic [WORD_W-1:0] accWord[$];
        int                startCyc[$];
        int                expBit[$];
        int                expCyc[$];
        int                freeCyc;
        int                endCyc;
        int                runLen;
        int                occ;
        int                lvl;
        int                expMax;
        int                expFirst;
        int                expLast;
        int                mism;
        int                width;
        int                base;
        int                gotV;
        int                expV;
        logic              stb;
        logic [WORD_W-1:0] w;
        logic [7:0]        hdr;

        hdr     = SYNC_WORD;
        freeCyc = 9;
        endCyc  = -1;
        for (int i = 0; i < schedCyc.size(); i++) begin
            if (schedCyc[i] >= 1 && schedWord[i] != IDLE_WORD) begin
                occ = accCyc.size();
                foreach (startCyc[k]) if (startCyc[k] - 1 < schedCyc[i]) occ--;
                if (occ >= DEPTH) begin
                    if (doCheck) ovfExp = 1'b1;
                end else begin
                    accCyc.push_back(schedCyc[i]);
                    accWord.push_back(schedWord[i]);
                    if (startCyc.size() < WPF) begin
                        startCyc.push_back((freeCyc > schedCyc[i] + 2) ? freeCyc : schedCyc[i] + 2);
                        freeCyc = startCyc[startCyc.size() - 1] + WORD_W;
                    end
                end
            end
        end
        if (startCyc.size() == WPF) endCyc = freeCyc;
        runLen = nCycles;
        if (runLen == 0) runLen = (endCyc > 0) ? endCyc + 2 : 400;

        capBit.delete();
        capCyc.delete();
        doneCnt    = 0;
        doneCyc    = -1;
        maxLevel   = 0;
        firstLevel = -1;
        lastLevel  = -1;
        cyc        = 0;
        for (int c = 0; c <= runLen; c++) begin
            stb = 1'b0;
            w   = '0;
            foreach (schedCyc[i]) begin
                if (schedCyc[i] == c) begin
                    stb = 1'b1;
                    w   = schedWord[i];
                end
            end
            applyStimulus(c == 0, stb, w);
        end
        schedCyc.delete();
        schedWord.delete();

        if (doCheck) begin
            for (int k = 0; k < 8; k++) begin
                expBit.push_back(int'(hdr[7-k]));
                expCyc.push_back(1 + k);
            end
            for (int j = 0; j < startCyc.size(); j++) begin
                for (int b = 0; b < WORD_W; b++) begin
                    expBit.push_back(int'(accWord[j][WORD_W-1-b]));
                    expCyc.push_back(startCyc[j] + b);
                end
            end
            checkOutput({tag, "_validBits"}, capBit.size(), expBit.size());
            mism = 0;
            foreach (expCyc[k]) if (k >= capCyc.size() || capCyc[k] != expCyc[k]) mism++;
            checkOutput({tag, "_validTimingErrors"}, mism, 0);
            for (int u = 0; u <= startCyc.size(); u++) begin
                width = (u == 0) ? 8 : WORD_W;
                base  = (u == 0) ? 0 : 8 + (u - 1) * WORD_W;
                gotV  = 0;
                expV  = 0;
                for (int b = 0; b < width; b++) begin
                    gotV = (gotV << 1) | ((base + b < capBit.size()) ? capBit[base + b] : 0);
                    expV = (expV << 1) | expBit[base + b];
                end
                checkOutput($sformatf("%s_unit%0d", tag, u), gotV, expV);
            end
            checkOutput({tag, "_doneCount"}, doneCnt, (endCyc > 0) ? 1 : 0);
            checkOutput({tag, "_doneCycle"}, doneCyc, endCyc);

            expMax   = 0;
            expFirst = 0;
            expLast  = 0;
            for (int c = 1; c <= runLen; c++) begin
                lvl = 0;
                foreach (accCyc[k]) if (accCyc[k] < c) lvl++;
                foreach (startCyc[k]) if (startCyc[k] - 1 < c) lvl--;
                if (lvl > expMax) expMax = lvl;
                if (c == 1) expFirst = lvl;
                expLast = lvl;
            end
            checkOutput({tag, "_levelFirst"}, firstLevel, expFirst);
            checkOutput({tag, "_levelMax"}, maxLevel, expMax);
            checkOutput({tag, "_levelLast"}, lastLevel, expLast);
            checkOutput({tag, "_overflow"}, int'(overflow), int'(ovfExp));
        end
    endtask

    // Main test sequence.
    initial begin
        int t;
        logic [WORD_W-1:0] rw;

        cyc = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_s_data", int'(s_data), 0);
        checkOutput("reset_data_valid", int'(data_valid), 0);
        checkOutput("reset_frame_done", int'(frame_done), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        checkOutput("reset_fifo_level", int'(fifo_level), 0);
        rst = 1'b0;

        addWord(1, 13'h0001);
        addWord(2, 13'h1010);
        addWord(3, 13'h1FFE);
        addWord(4, 13'h0ABC);
        runFrame("nominal", 0, 1'b1);

        addWord(1, 13'h0003);
        addWord(2, 13'h1FFF);
        addWord(3, 13'h0004);
        addWord(4, 13'h1FFF);
        addWord(5, 13'h0005);
        addWord(6, 13'h0006);
        runFrame("idleFilter", 0, 1'b1);

        addWord(1, 13'h0111);
        addWord(41, 13'h0222);
        addWord(81, 13'h1333);
        addWord(121, 13'h0444);
        runFrame("starved", 0, 1'b1);

        for (int f = 0; f < 6; f++) begin
            t = $urandom_range(1, 6);
            for (int n = 0; n < WPF; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    addWord(t, IDLE_WORD);
                    t += 1 + $urandom_range(0, 3);
                end
                rw = WORD_W'($urandom_range(0, 13'h1FFE));
                addWord(t, rw);
                t += 1 + $urandom_range(0, 20);
            end
            runFrame($sformatf("random%0d", f), 0, 1'b1);
        end

        addWord(1, 13'h0AAA);
        addWord(2, 13'h0BBB);
        addWord(3, 13'h0CCC);
        addWord(4, 13'h0DDD);
        runFrame("abortPre", 27, 1'b0);
        checkOutput("abortPre_doneCount", doneCnt, 0);
        checkOutput("abortPre_level", lastLevel, 2);
        addWord(0, 13'h0777);
        for (int n = 0; n < WPF; n++) begin
            rw = WORD_W'($urandom_range(0, 13'h1FFE));
            addWord(2 + 3 * n, rw);
        end
        runFrame("abortNew", 0, 1'b1);

        for (int n = 1; n <= 10; n++) addWord(n, WORD_W'(n));
        runFrame("overflow", 0, 1'b1);

        addWord(1, 13'h0100);
        addWord(2, 13'h0200);
        runFrame("resetPre", 15, 1'b0);
        @(negedge clk);
        rst         = 1'b1;
        frame_start = 1'b0;
        word_stb    = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        ovfExp = 1'b0;
        checkOutput("midReset_s_data", int'(s_data), 0);
        checkOutput("midReset_data_valid", int'(data_valid), 0);
        checkOutput("midReset_frame_done", int'(frame_done), 0);
        checkOutput("midReset_overflow", int'(overflow), 0);
        checkOutput("midReset_fifo_level", int'(fifo_level), 0);
        word_stb = 1'b1;
        word_in  = 13'h0005;
        @(negedge clk);
        word_stb = 1'b0;
        @(negedge clk);
        checkOutput("idleDrop_fifo_level", int'(fifo_level), 0);
        checkOutput("idleDrop_data_valid", int'(data_valid), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    // Guards against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
